activation_flow_controller: RTL
===============================

ACTIVATION_FLOW_CONTROLLER -- requirements
Module: activation_flow_controller

Interface
REQ-001 SHALL have parameter MATRIX_WIDTH, default 14, systolic array width (passed through for package consistency).
REQ-002 SHALL have parameter ACC_READ_LATENCY, default 2, cycles from accumulator read address to data valid.
REQ-003 SHALL have parameter ACT_LATENCY, default 3, cycles through activation unit.
REQ-004 SHALL use one clock and a synchronous active-high reset, with ports clk and rst.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 enable  input  1  global advance; low stalls all state.
REQ-008 instr  input  instr_type  instruction {opcode 8, length, acc_addr, buffer_addr}.
REQ-009 instr_enable  input  1  instruction valid strobe.
REQ-010 acc_to_act_addr  output  accumulator_addr_type  accumulator read address.
REQ-011 acc_read_enable  output  1  accumulator read strobe.
REQ-012 activation_function  output  activation_type  opcode[3:0], aligned to data entering activation unit.
REQ-013 is_act_signed  output  1  opcode[4], aligned as activation_function.
REQ-014 act_to_buffer_addr  output  buffer_addr_type  unified buffer write address.
REQ-015 buffer_write_enable  output  1  unified buffer write strobe.
REQ-016 busy  output  1  instruction in flight.
REQ-017 resource_busy  output  1  accumulator read port in use.

Function
REQ-018 SHALL accept instr on a rising edge with instr_enable=1, enable=1, busy=0; otherwise instr_enable ignored, no queuing.
REQ-019 On acceptance with length>0: busy and resource_busy high next cycle; latch acc_addr, buffer_addr, opcode, length.
REQ-020 SHALL issue acc_read_enable=1 for length consecutive enabled cycles starting the cycle after acceptance, address acc_addr+i, i=0..length-1.
REQ-021 Address arithmetic SHALL wrap modulo the address type width (no carry into other fields).
REQ-022 buffer_write_enable/act_to_buffer_addr SHALL be acc_read_enable/index delayed exactly ACC_READ_LATENCY+ACT_LATENCY enabled cycles, address buffer_addr+i.
REQ-023 activation_function/is_act_signed SHALL be latched opcode fields delayed ACC_READ_LATENCY enabled cycles; default state when idle.
REQ-024 States: IDLE -> READ (issuing reads) -> DRAIN (pipeline emptying) -> IDLE.
REQ-025 resource_busy SHALL fall the cycle after the last read; busy SHALL fall the cycle after the last buffer write.
REQ-026 length=0 SHALL be accepted as a no-op: no strobes, busy stays low.
REQ-027 enable=0 SHALL freeze counters, FSM and delay pipeline; strobe outputs held low during the stall, then resume with no lost or duplicated index.
REQ-028 Strobe outputs SHALL never be high with enable=0.

Reset
REQ-029 rst=1 at any time, mid-operation included, SHALL force IDLE, clear pipeline and counters; all outputs 0 (activation_function = NO_ACTIVATION) next cycle.
REQ-030 rst SHALL override instr_enable in the same cycle.

Structure
REQ-031 tpu_pkg SHALL hold instr_type, accumulator_addr_type, buffer_addr_type, activation_type enum, INIT_INSTR and the ACTIVATE opcode mask (opcode[7:5]=3'b100).
REQ-032 SHALL instantiate one sub-module, act_delay_pipe: parameterised-depth, enable-gated, reset-cleared register chain reused for strobe, address and function alignment.

Verification
REQ-033 opcode 8'b1000_0001, length 29, acc_addr 0x0049, buffer_addr 0x009463 -> reads 0x0049..0x0065 on 29 cycles; writes 0x009463..0x00947F starting 5 cycles after first read; busy low cycle after last write.
REQ-034 Same instr, enable low 3 cycles after read 10 -> no strobes during stall, all 29 reads/writes exactly once, completion 3 cycles later.
REQ-035 Second instr_enable while busy -> ignored; only first instruction's 29 reads appear.
REQ-036 acc_addr 0xFFFE, length 4 -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-037 rst asserted at read 7 -> next cycle all outputs 0, IDLE; fresh length 14 instr then completes normally.
REQ-038 length 0 -> no strobes, busy never high; following instr accepted next cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types for the activation datapath: instruction layout, address widths
// and the activation function encoding carried in opcode[3:0].
package tpu_pkg;

    localparam int unsigned OPCODE_W   = 8;
    localparam int unsigned LENGTH_W   = 32;
    localparam int unsigned ACC_ADDR_W = 16;
    localparam int unsigned BUF_ADDR_W = 24;

    typedef logic [OPCODE_W-1:0]   opcode_type;
    typedef logic [LENGTH_W-1:0]   length_type;
    typedef logic [ACC_ADDR_W-1:0] accumulator_addr_type;
    typedef logic [BUF_ADDR_W-1:0] buffer_addr_type;

    typedef struct packed {
        opcode_type           opcode;
        length_type           length;
        accumulator_addr_type acc_addr;
        buffer_addr_type      buffer_addr;
    } instr_type;

    typedef enum logic [3:0] {
        NO_ACTIVATION = 4'd0,
        RELU          = 4'd1,
        RELU6         = 4'd2,
        CRELU         = 4'd3,
        ELU           = 4'd4,
        SELU          = 4'd5,
        SOFTPLUS      = 4'd6,
        SOFTSIGN      = 4'd7,
        DROPOUT       = 4'd8,
        SIGMOID       = 4'd9,
        TANH          = 4'd10
    } activation_type;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } flow_state_t;

    localparam instr_type  INIT_INSTR      = '0;
    localparam logic [2:0] ACTIVATE_OPCODE = 3'b100;
    localparam opcode_type ACTIVATE_MASK   = 8'b1110_0000;

    // ACTIVATE instructions are identified by opcode[7:5] alone.
    function automatic logic is_activate(input opcode_type op);
        return (op & ACTIVATE_MASK) == {ACTIVATE_OPCODE, 5'b0_0000};
    endfunction

endpackage

// File: rtl/act_delay_pipe.sv
// Enable-gated, reset-cleared register chain used to align strobes, addresses
// and activation selects with the accumulator and activation unit latencies.
module act_delay_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_chain
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/activation_flow_controller.sv
// Sequences one ACTIVATE instruction: streams accumulator reads, then aligns the
// activation select and unified-buffer writes to the downstream pipeline latency.
module activation_flow_controller
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_WIDTH     = 14,
    parameter int unsigned ACC_READ_LATENCY = 2,
    parameter int unsigned ACT_LATENCY      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  instr_type            instr,
    input  logic                 instr_enable,
    output accumulator_addr_type acc_to_act_addr,
    output logic                 acc_read_enable,
    output activation_type       activation_function,
    output logic                 is_act_signed,
    output buffer_addr_type      act_to_buffer_addr,
    output logic                 buffer_write_enable,
    output logic                 busy,
    output logic                 resource_busy,
    output flow_state_t          state_o
);

    localparam int unsigned WRITE_DELAY = ACC_READ_LATENCY + ACT_LATENCY;

    flow_state_t          state_q;
    length_type           idx_q;
    length_type           len_q;
    accumulator_addr_type acc_addr_q;
    buffer_addr_type      buf_base_q;
    logic [4:0]           func_q;
    logic [7:0]           drain_q;
    logic                 busy_q;
    logic                 res_busy_q;

    logic                 read_active;
    buffer_addr_type      wr_addr_in;
    logic [4:0]           func_in;
    logic [BUF_ADDR_W:0]  wr_pipe_out;
    logic [4:0]           func_pipe_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            acc_addr_q <= '0;
            buf_base_q <= '0;
            func_q     <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            res_busy_q <= 1'b0;
        end else if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    // A zero-length instruction is consumed without leaving IDLE.
                    if (instr_enable && (instr.length != '0)) begin
                        state_q    <= ST_READ;
                        idx_q      <= '0;
                        len_q      <= instr.length;
                        acc_addr_q <= instr.acc_addr;
                        buf_base_q <= instr.buffer_addr;
                        func_q     <= instr.opcode[4:0];
                        busy_q     <= 1'b1;
                        res_busy_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (idx_q == len_q - length_type'(1)) begin
                        res_busy_q <= 1'b0;
                        if (WRITE_DELAY == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DRAIN;
                            drain_q <= 8'(WRITE_DELAY - 1);
                        end
                    end else begin
                        idx_q      <= idx_q + length_type'(1);
                        acc_addr_q <= acc_addr_q + accumulator_addr_type'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 8'd0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= drain_q - 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign read_active = (state_q == ST_READ);
    assign wr_addr_in  = read_active ? (buf_base_q + buffer_addr_type'(idx_q)) : '0;
    assign func_in     = read_active ? func_q : 5'd0;

    act_delay_pipe #(
        .WIDTH (BUF_ADDR_W + 1),
        .DEPTH (WRITE_DELAY)
    ) u_write_pipe (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (enable),
        .d_i   ({read_active, wr_addr_in}),
        .q_o   (wr_pipe_out)
    );

    act_delay_pipe #(
        .WIDTH (5),
        .DEPTH (ACC_READ_LATENCY)
    ) u_func_pipe (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (enable),
        .d_i   (func_in),
        .q_o   (func_pipe_out)
    );

    // Strobes are masked by enable so nothing fires while the datapath is stalled.
    assign acc_read_enable     = read_active & enable;
    assign acc_to_act_addr     = acc_addr_q;
    assign buffer_write_enable = wr_pipe_out[BUF_ADDR_W] & enable;
    assign act_to_buffer_addr  = wr_pipe_out[BUF_ADDR_W-1:0];
    assign activation_function = activation_type'(func_pipe_out[3:0]);
    assign is_act_signed       = func_pipe_out[4];
    assign busy                = busy_q;
    assign resource_busy       = res_busy_q;
    assign state_o             = state_q;

    logic unused_ok;
    assign unused_ok = ^{instr.opcode[7:5], 32'(MATRIX_WIDTH)};

endmodule
